// File: rtl/prewitt_pkg.sv
// Shared definitions for the Prewitt edge pipeline: kernel mode encoding and
// the raster sequencer state type.
package prewitt_pkg;

  localparam logic [1:0] MODE_HOR  = 2'd0;
  localparam logic [1:0] MODE_VER  = 2'd1;
  localparam logic [1:0] MODE_BOTH = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } ctrl_state_t;

  // The reserved code behaves exactly like the combined-magnitude mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_BOTH : m;
  endfunction

endpackage

// File: rtl/prewitt_stream_ctrl_raster_counter.sv
// Row/column raster position counter with synchronous clear, advance enable
// and end-of-frame flag; wraps to (0,0) after the last pixel.
module raster_counter
  import prewitt_pkg::*;
#(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int ROW_W = 8,
  parameter int COL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic col_wrap;

  assign col_wrap = (col == COL_MAX);
  assign last     = col_wrap && (row == ROW_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prewitt_stream_ctrl.sv
// Raster-scan sequencer for the streaming Prewitt datapath: paces pixel input,
// addresses the line buffers and tags each result with row/col/border.
module prewitt_stream_ctrl
  import prewitt_pkg::*;
#(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int ROW_W = 8,
  parameter int COL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode_in,
  output logic [1:0]       cfg_mode,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [COL_W-1:0] lb_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             out_border
);

  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] FILL_ROW = ROW_W'(1);

  ctrl_state_t state, state_nxt;

  logic [1:0]       cfg_mode_nxt;
  logic             vld_p1, vld_nxt;
  logic             done_nxt;
  logic             cnt_clr;
  logic             out_hs;
  logic             on_edge;
  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] in_col;
  logic             in_last;
  logic             out_last;

  // Input side: position of the pixel being offered.
  raster_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_in_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (shift_en),
    .row  (in_row),
    .col  (in_col),
    .last (in_last)
  );

  // Output side: the counter itself is the result tag, so it is naturally
  // held while the downstream stalls and advances only on a handshake.
  raster_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_out_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (out_hs),
    .row  (out_row),
    .col  (out_col),
    .last (out_last)
  );

  assign in_ready = (state == ST_FILL) ||
                    ((state == ST_RUN) && (!vld_p1 || out_ready));
  assign shift_en = in_valid && in_ready;
  assign out_hs   = vld_p1 && out_ready;
  assign lb_addr  = in_col;

  assign on_edge    = (out_row == '0) || (out_row == ROW_MAX) ||
                      (out_col == '0) || (out_col == COL_MAX);
  assign out_border = vld_p1 && on_edge;
  assign out_valid  = vld_p1;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cfg_mode <= MODE_HOR;
      vld_p1   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg_mode <= cfg_mode_nxt;
      vld_p1   <= vld_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cfg_mode_nxt = cfg_mode;
    vld_nxt      = vld_p1;
    done_nxt     = 1'b0;
    cnt_clr      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cfg_mode_nxt = norm_mode(mode_in);
          cnt_clr      = 1'b1;
          state_nxt    = ST_FILL;
        end
      end
      // The window needs one full line plus one pixel before its centre
      // lands on (0,0); that pixel is the one at input position (1,0).
      ST_FILL: begin
        if (shift_en && (in_row == FILL_ROW) && (in_col == '0)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        vld_nxt = shift_en || (vld_p1 && !out_ready);
        if (shift_en && in_last) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_hs && out_last) begin
          vld_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prewitt_stream_ctrl.sv
// Bench for prewitt_stream_ctrl: a 4x5 instance for directed/randomised frame
// scenarios and a full-size 242x247 instance for one random-gap frame.
module tb_prewitt_stream_ctrl;

  localparam int SR = 4;
  localparam int SC = 5;
  localparam int SN = SR * SC;
  localparam int LR = 242;
  localparam int LC = 247;
  localparam int LN = LR * LC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int is_border(input int r, input int c, input int nr, input int nc);
    return (r == 0 || r == nr - 1 || c == 0 || c == nc - 1) ? 1 : 0;
  endfunction

  // ---------------- small instance ----------------
  logic       s_rst_n, s_start, s_in_valid, s_out_ready;
  logic [1:0] s_mode_in, s_cfg_mode;
  logic       s_busy, s_done, s_in_ready, s_shift_en, s_out_valid, s_out_border;
  logic [7:0] s_lb_addr, s_out_row, s_out_col;

  prewitt_stream_ctrl #(.ROWS(SR), .COLS(SC), .ROW_W(8), .COL_W(8)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .mode_in(s_mode_in),
    .cfg_mode(s_cfg_mode), .busy(s_busy), .done(s_done),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .shift_en(s_shift_en),
    .lb_addr(s_lb_addr), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row(s_out_row), .out_col(s_out_col), .out_border(s_out_border)
  );

  // ---------------- full-size instance ----------------
  logic       l_rst_n, l_start, l_in_valid, l_out_ready;
  logic [1:0] l_mode_in, l_cfg_mode;
  logic       l_busy, l_done, l_in_ready, l_shift_en, l_out_valid, l_out_border;
  logic [7:0] l_lb_addr, l_out_row, l_out_col;

  prewitt_stream_ctrl #(.ROWS(LR), .COLS(LC), .ROW_W(8), .COL_W(8)) dut_l (
    .clk(clk), .rst_n(l_rst_n), .start(l_start), .mode_in(l_mode_in),
    .cfg_mode(l_cfg_mode), .busy(l_busy), .done(l_done),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .shift_en(l_shift_en),
    .lb_addr(l_lb_addr), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_row(l_out_row), .out_col(l_out_col), .out_border(l_out_border)
  );

  // Small-instance model state: pixel k enters at raster index k, result k
  // is tag (k/COLS, k%COLS) and may exist only once pixel k+COLS+1 is in.
  int         s_acc, s_out, s_first_acc, s_first_out, s_last_hs, s_done_cnt;
  int         s_border, s_int_n, s_int_sum, s_first_tag, s_need;
  bit         s_stall;
  logic [7:0] s_prev_row, s_prev_col;
  logic [1:0] s_exp_mode;

  always @(negedge clk) begin
    if (!s_rst_n || (s_start && !s_busy)) begin
      s_acc = 0; s_out = 0; s_first_acc = -1; s_first_out = -1; s_last_hs = -1;
      s_done_cnt = 0; s_border = 0; s_int_n = 0; s_int_sum = 0; s_first_tag = -1;
      s_stall = 0;
    end else begin
      chk("s_shift_en", int'(s_shift_en), int'(s_in_valid & s_in_ready));
      if (!s_busy) chk("s_idle_in_ready", int'(s_in_ready), 0);
      if (s_busy) chk("s_cfg_mode", int'(s_cfg_mode), int'(s_exp_mode));
      if (s_acc == SN) chk("s_flush_in_ready", int'(s_in_ready), 0);
      if (s_out_valid && !s_out_ready) chk("s_stall_in_ready", int'(s_in_ready), 0);
      if (s_stall) begin
        chk("s_stall_valid", int'(s_out_valid), 1);
        chk("s_stall_row", int'(s_out_row), int'(s_prev_row));
        chk("s_stall_col", int'(s_out_col), int'(s_prev_col));
      end
      if (s_out_valid) begin
        s_need = s_out + SC + 2;
        if (s_need > SN) s_need = SN;
        chk("s_tag_available", int'(s_acc >= s_need), 1);
        chk("s_no_extra_tag", int'(s_out < SN), 1);
      end
      if (s_out_valid && s_out_ready) begin
        chk("s_out_row", int'(s_out_row), s_out / SC);
        chk("s_out_col", int'(s_out_col), s_out % SC);
        chk("s_out_border", int'(s_out_border), is_border(s_out / SC, s_out % SC, SR, SC));
        if (s_out_border) s_border++;
        else begin
          s_int_n++;
          s_int_sum += int'(s_out_row) * 10 + int'(s_out_col);
        end
        if (s_out == 0) begin
          s_first_out = cyc;
          s_first_tag = int'(s_out_row) * 10 + int'(s_out_col);
        end
        s_last_hs = cyc;
        s_out++;
      end
      if (s_shift_en) begin
        chk("s_lb_addr", int'(s_lb_addr), s_acc % SC);
        if (s_acc == 0) s_first_acc = cyc;
        s_acc++;
      end
      if (s_done) begin
        chk("s_done_all_out", s_out, SN);
        chk("s_done_timing", cyc, s_last_hs + 1);
        chk("s_done_busy_low", int'(s_busy), 0);
        s_done_cnt++;
      end
      s_stall    = s_out_valid && !s_out_ready;
      s_prev_row = s_out_row;
      s_prev_col = s_out_col;
    end
  end

  // Full-size instance model state.
  int l_acc, l_out, l_border, l_fb, l_done_cnt, l_last_tag, l_need;

  always @(negedge clk) begin
    if (!l_rst_n || (l_start && !l_busy)) begin
      l_acc = 0; l_out = 0; l_border = 0; l_fb = 0; l_done_cnt = 0; l_last_tag = -1;
    end else begin
      if (!l_busy) chk("l_idle_in_ready", int'(l_in_ready), 0);
      if (l_busy) chk("l_cfg_mode", int'(l_cfg_mode), 2);
      if (l_out_valid) begin
        l_need = l_out + LC + 2;
        if (l_need > LN) l_need = LN;
        chk("l_tag_available", int'(l_acc >= l_need), 1);
      end
      if (l_out_valid && l_out_ready) begin
        chk("l_out_row", int'(l_out_row), l_out / LC);
        chk("l_out_col", int'(l_out_col), l_out % LC);
        chk("l_out_border", int'(l_out_border), is_border(l_out / LC, l_out % LC, LR, LC));
        if (l_out_border) begin
          l_border++;
          if (l_out >= LN - (LC + 1)) l_fb++;
        end
        l_last_tag = int'(l_out_row) * 1000 + int'(l_out_col);
        l_out++;
      end
      if (l_shift_en) begin
        chk("l_lb_addr", int'(l_lb_addr), l_acc % LC);
        l_acc++;
      end
      if (l_done) begin
        chk("l_done_all_out", l_out, LN);
        l_done_cnt++;
      end
    end
  end

  task automatic zero_s(input string tag);
    chk({tag, "_busy"}, int'(s_busy), 0);
    chk({tag, "_done"}, int'(s_done), 0);
    chk({tag, "_out_valid"}, int'(s_out_valid), 0);
    chk({tag, "_in_ready"}, int'(s_in_ready), 0);
    chk({tag, "_shift_en"}, int'(s_shift_en), 0);
    chk({tag, "_cfg_mode"}, int'(s_cfg_mode), 0);
    chk({tag, "_lb_addr"}, int'(s_lb_addr), 0);
    chk({tag, "_out_row"}, int'(s_out_row), 0);
    chk({tag, "_out_col"}, int'(s_out_col), 0);
    chk({tag, "_out_border"}, int'(s_out_border), 0);
  endtask

  // rdy_pat: 0 = always ready, 1 = toggle every cycle, 2 = random.
  task automatic frame_s(input logic [1:0] mode, input int rdy_pat,
                         input bit mid_start, input int rst_after);
    @(posedge clk); #1;
    s_exp_mode = mode; s_mode_in = mode; s_start = 1'b1;
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_mode_in = 2'($urandom_range(0, 3));
    for (int i = 0; i < 300; i++) begin
      if (s_done_cnt > 0) break;
      if (rst_after >= 0 && s_acc >= rst_after) begin
        #2 s_rst_n = 1'b0;
        #1 zero_s("s_midrst");
        @(posedge clk); #1 s_rst_n = 1'b1;
        break;
      end
      if (rdy_pat == 1) s_out_ready = ~s_out_ready;
      else if (rdy_pat == 2) s_out_ready = 1'($urandom_range(0, 1));
      if (mid_start && i == 8) begin
        s_start = 1'b1; s_mode_in = 2'd0;
      end else begin
        s_start = 1'b0;
      end
      if (i == 3 && mode == 2'd1) chk("s_cfg_mode_lit", int'(s_cfg_mode), 1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; s_start = 1'b0; s_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic end_chk_s(input string tag);
    chk({tag, "_done_once"}, s_done_cnt, 1);
    chk({tag, "_n_out"}, s_out, 20);
    chk({tag, "_n_acc"}, s_acc, 20);
    chk({tag, "_n_border"}, s_border, 14);
    chk({tag, "_n_interior"}, s_int_n, 6);
    chk({tag, "_interior_sum"}, s_int_sum, 102);
    chk({tag, "_first_tag"}, s_first_tag, 0);
  endtask

  initial begin
    s_rst_n = 1'b0; s_start = 1'b0; s_mode_in = 2'd0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    l_rst_n = 1'b0; l_start = 1'b0; l_mode_in = 2'd0; l_in_valid = 1'b0; l_out_ready = 1'b0;
    s_exp_mode = 2'd0;
    #12;
    zero_s("s_por");
    chk("l_por_busy", int'(l_busy), 0);
    chk("l_por_out_valid", int'(l_out_valid), 0);
    chk("l_por_in_ready", int'(l_in_ready), 0);
    @(posedge clk); #1;
    s_rst_n = 1'b1; l_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Continuous streaming: exact latency and done timing are pinned here.
    frame_s(2'd1, 0, 1'b0, -1);
    end_chk_s("f1");
    chk("f1_first_out_latency", s_first_out - s_first_acc, 7);
    chk("f1_last_hs_cycle", s_last_hs - s_first_acc, 26);

    // Downstream back-pressure on alternate cycles.
    frame_s(2'd1, 1, 1'b0, -1);
    end_chk_s("f2");

    // A second start mid-frame must be ignored.
    frame_s(2'd1, 0, 1'b1, -1);
    end_chk_s("f3");

    // Reset after 10 accepted pixels: discarded frame, no done pulse.
    frame_s(2'd1, 0, 1'b0, 10);
    chk("f4_no_done", s_done_cnt, 0);
    chk("f4_busy_after_rst", int'(s_busy), 0);

    // Clean frame afterwards, random back-pressure.
    frame_s(2'd2, 2, 1'b0, -1);
    end_chk_s("f5");

    // Full-size frame with random input gaps.
    @(posedge clk); #1;
    l_mode_in = 2'd2; l_start = 1'b1; l_in_valid = 1'b1; l_out_ready = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    for (int i = 0; i < 80000 && l_done_cnt == 0; i++) begin
      l_in_valid = ($urandom_range(0, 31) != 0);
      @(posedge clk); #1;
    end
    l_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l_done_once", l_done_cnt, 1);
    chk("l_n_out", l_out, 59774);
    chk("l_n_acc", l_acc, 59774);
    chk("l_last_tag", l_last_tag, 241246);
    chk("l_flush_border", l_fb, 248);
    chk("l_n_border", l_border, 974);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
